pwm_deadtime_gen: RTL and testbench
===================================

// Module: pwm_deadtime_gen
// PURPOSE
//   Complementary-output stage placed directly downstream of a PWM comparator channel.
//   Converts one PWM waveform into a high-side / low-side gate-drive pair.
//   Inserts a programmable dead time at every transition, so both outputs are never high together.
//   Adds a latched emergency break input and a saturating counter of absorbed short pulses.
//   One instance per channel (PWM1_OUT, PWM2_OUT). dt_rise/dt_fall/enable come from the PWM register block.
// PARAMETERS
//   DT_WIDTH   16   width of the dead-time count inputs
//   SCNT_WIDTH 8    width of the short-pulse counter (saturating)
// PORTS
//   clk        in   1           system clock; all logic on rising edge
//   rst_n      in   1           synchronous, active-low reset
//   enable     in   1           channel enable; 0 forces IDLE (both outputs low)
//   pwm_in     in   1           PWM from comparator, same clock domain, sampled every edge
//   dt_rise    in   DT_WIDTH    dead cycles between out_lo falling and out_hi rising
//   dt_fall    in   DT_WIDTH    dead cycles between out_hi falling and out_lo rising
//   brk        in   1           emergency break, level, sampled every edge
//   brk_clr    in   1           clears brk_flag (ignored while brk=1)
//   out_hi     out  1           high-side drive, registered
//   out_lo     out  1           low-side drive, registered
//   dt_active  out  1           1 while in DT_RISE or DT_FALL
//   brk_flag   out  1           latched break status
//   short_cnt  out  SCNT_WIDTH  count of pwm_in pulses shorter than the dead time
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE; out_hi=out_lo=dt_active=brk_flag=0; cnt=0; short_cnt=0.
//   All outputs are flops updated on the same edge as the state. There is no combinational path from inputs to outputs.
//   States:
//     IDLE     both outputs 0
//     LO_ON    out_lo=1
//     DT_RISE  both outputs 0
//     HI_ON    out_hi=1
//     DT_FALL  both outputs 0
//   Priority at each edge: rst_n=0 > brk=1 > brk_flag=1 or enable=0 > normal transitions.
//   brk=1: next state IDLE and brk_flag<=1, from any state. Both outputs are 0 one edge after brk is sampled.
//   brk_flag stays 1 until an edge with brk_clr=1 and brk=0. If brk and brk_clr are both 1, brk wins.
//   While brk_flag=1 or enable=0, the block stays in IDLE.
//   IDLE exit (enable=1, brk_flag=0):
//     pwm_in=1 -> DT_RISE, cnt<=dt_rise
//     pwm_in=0 -> DT_FALL, cnt<=dt_fall
//     Start-up therefore always passes through a dead time.
//   LO_ON: pwm_in=1 -> DT_RISE, cnt<=dt_rise.
//   HI_ON: pwm_in=0 -> DT_FALL, cnt<=dt_fall.
//   DT_RISE:
//     pwm_in=0 -> LO_ON (pulse absorbed, out_hi never asserted); short_cnt+1, saturating.
//     else cnt<=1 -> HI_ON.
//     else cnt<=cnt-1.
//   DT_FALL: symmetric. pwm_in=1 -> HI_ON and short_cnt+1; else cnt<=1 -> LO_ON; else decrement.
//   Dead time = max(dt,1) cycles with both outputs low. A value of 0 is treated as 1, so the outputs never overlap.
//   Latency: the active output falls at the first edge that samples the pwm_in change. The opposite output rises max(dt,1) edges later.
//   dt_rise/dt_fall are captured only on entry to a DT state. Changes mid-count take effect at the next transition.
//   short_cnt saturates at all-ones and clears only on reset.
//   Invariant: out_hi & out_lo == 0 on every cycle.
// TESTING
//   T1 dt_rise=4, dt_fall=3, enable=1, pwm_in=0 ->
//      out_lo rises 3 edges after enable; both stay low for exactly 3 cycles before that.
//   T2 then pwm_in=1 for 20 cycles, then 0 ->
//      out_lo falls at the first sampling edge; out_hi rises 4 edges later;
//      out_hi falls at the first edge sampling 0; out_lo rises 3 edges later.
//   T3 dt_rise=0, dt_fall=0, toggle pwm_in every 6 cycles -> exactly 1-cycle gap at each transition; dt_active high for 1 cycle.
//   T4 dt_rise=5, pwm_in high for 2 cycles from LO_ON ->
//      out_hi stays 0; out_lo returns 1 at the edge sampling pwm_in=0; short_cnt 0->1.
//   T5 brk pulsed 1 cycle during HI_ON ->
//      both outputs 0 next edge; brk_flag=1; toggling enable/pwm_in has no effect;
//      brk_clr=1 -> brk_flag=0, then restart through DT_RISE or DT_FALL.
//   T6 rst_n=0 for one edge mid-DT_RISE -> all outputs and short_cnt 0 after that edge.
//      rst_n low between edges has no effect until the edge.
//      Separately, 300 short pulses -> short_cnt holds at 255.

Source files
------------

// File: rtl/pwm_deadtime_gen_if.sv
// Control and drive bundle for one complementary PWM channel.
// The master side (register block / comparator) drives the controls;
// the slave side (the dead-time stage) returns the gate drives and status.
interface pwm_deadtime_gen_if #(
  parameter int DT_WIDTH   = 16,
  parameter int SCNT_WIDTH = 8
);
  logic                  enable;
  logic                  pwm_in;
  logic [DT_WIDTH-1:0]   dt_rise;
  logic [DT_WIDTH-1:0]   dt_fall;
  logic                  brk;
  logic                  brk_clr;
  logic                  out_hi;
  logic                  out_lo;
  logic                  dt_active;
  logic                  brk_flag;
  logic [SCNT_WIDTH-1:0] short_cnt;

  modport master (
    output enable, pwm_in, dt_rise, dt_fall, brk, brk_clr,
    input  out_hi, out_lo, dt_active, brk_flag, short_cnt
  );

  modport slave (
    input  enable, pwm_in, dt_rise, dt_fall, brk, brk_clr,
    output out_hi, out_lo, dt_active, brk_flag, short_cnt
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive stage with programmable dead time, latched
// emergency break and a saturating counter of absorbed short pulses.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | disabled, broken or just started; both drives low
// LO_ON   | low-side drive on
// DT_RISE | dead time before high side turns on; both drives low
// HI_ON   | high-side drive on
// DT_FALL | dead time before low side turns on; both drives low
module pwm_deadtime_gen #(
  parameter int DT_WIDTH   = 16,
  parameter int SCNT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  pwm_deadtime_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_ON   = 3'd1,
    DT_RISE = 3'd2,
    HI_ON   = 3'd3,
    DT_FALL = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  out_hi_q, out_hi_d;
  logic                  out_lo_q, out_lo_d;
  logic                  dt_active_q, dt_active_d;
  logic                  brk_flag_q, brk_flag_d;
  logic [SCNT_WIDTH-1:0] short_cnt_q, short_cnt_d;
  logic                  short_hit;
  logic                  cnt_done;

  // A dead-time count of 0 or 1 both end on the next edge, so 0 behaves as 1.
  assign cnt_done = (cnt_q <= DT_WIDTH'(1));

  // Next-state, dead-time counter and break-latch decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    brk_flag_d = brk_flag_q;
    short_hit  = 1'b0;

    if (bus.brk) begin
      state_d    = IDLE;
      brk_flag_d = 1'b1;
    end else if (brk_flag_q || !bus.enable) begin
      state_d = IDLE;
      if (brk_flag_q && bus.brk_clr) begin
        brk_flag_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // Leaving IDLE always goes through a dead time first.
          if (bus.pwm_in) begin
            state_d = DT_RISE;
            cnt_d   = bus.dt_rise;
          end else begin
            state_d = DT_FALL;
            cnt_d   = bus.dt_fall;
          end
        end
        LO_ON: begin
          if (bus.pwm_in) begin
            state_d = DT_RISE;
            cnt_d   = bus.dt_rise;
          end
        end
        HI_ON: begin
          if (!bus.pwm_in) begin
            state_d = DT_FALL;
            cnt_d   = bus.dt_fall;
          end
        end
        DT_RISE: begin
          if (!bus.pwm_in) begin
            state_d   = LO_ON;
            short_hit = 1'b1;
          end else if (cnt_done) begin
            state_d = HI_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        DT_FALL: begin
          if (bus.pwm_in) begin
            state_d   = HI_ON;
            short_hit = 1'b1;
          end else if (cnt_done) begin
            state_d = LO_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Drives and status are decoded from the next state so they register on
  // the same edge as the state itself.
  always_comb begin
    out_hi_d    = (state_d == HI_ON);
    out_lo_d    = (state_d == LO_ON);
    dt_active_d = (state_d == DT_RISE) || (state_d == DT_FALL);
    short_cnt_d = short_cnt_q;
    if (short_hit && (short_cnt_q != {SCNT_WIDTH{1'b1}})) begin
      short_cnt_d = short_cnt_q + SCNT_WIDTH'(1);
    end
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_hi_q    <= 1'b0;
      out_lo_q    <= 1'b0;
      dt_active_q <= 1'b0;
      brk_flag_q  <= 1'b0;
      short_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_hi_q    <= out_hi_d;
      out_lo_q    <= out_lo_d;
      dt_active_q <= dt_active_d;
      brk_flag_q  <= brk_flag_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign bus.out_hi    = out_hi_q;
  assign bus.out_lo    = out_lo_q;
  assign bus.dt_active = dt_active_q;
  assign bus.brk_flag  = brk_flag_q;
  assign bus.short_cnt = short_cnt_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen. Stimulus queues hand-computed
// expectations tagged with the edge they apply to; a negedge monitor
// compares them against the DUT and also checks the no-overlap invariant.
module tb_pwm_deadtime_gen;

  logic clk;
  logic rst_n;
  int   edges;
  int   checks;
  int   failures;

  pwm_deadtime_gen_if #(.DT_WIDTH(16), .SCNT_WIDTH(8)) bus ();

  pwm_deadtime_gen #(.DT_WIDTH(16), .SCNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         edge_no;
    string      name;
    logic       hi;
    logic       lo;
    logic       dta;
    logic       flg;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges = edges + 1;

  task automatic expect_at(input int off, input string nm, input logic hi,
                           input logic lo, input logic dta, input logic flg,
                           input logic [7:0] sc);
    exp_t e;
    e.edge_no = edges + off;
    e.name    = nm;
    e.hi      = hi;
    e.lo      = lo;
    e.dta     = dta;
    e.flg     = flg;
    e.sc      = sc;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation that is due at this edge.
  always @(negedge clk) begin
    if (edges > 0) begin
      checks = checks + 1;
      if ((bus.out_hi & bus.out_lo) !== 1'b0) begin
        failures = failures + 1;
        $display("FAIL overlap edge=%0d got hi=%b lo=%b expected not both 1",
                 edges, bus.out_hi, bus.out_lo);
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edge_no == edges) begin
        checks = checks + 1;
        if ({bus.out_hi, bus.out_lo, bus.dt_active, bus.brk_flag, bus.short_cnt} !==
            {sb[i].hi, sb[i].lo, sb[i].dta, sb[i].flg, sb[i].sc}) begin
          failures = failures + 1;
          $display("FAIL %s edge=%0d got hi=%b lo=%b dta=%b flg=%b sc=%0d expected hi=%b lo=%b dta=%b flg=%b sc=%0d",
                   sb[i].name, edges, bus.out_hi, bus.out_lo, bus.dt_active,
                   bus.brk_flag, bus.short_cnt, sb[i].hi, sb[i].lo, sb[i].dta,
                   sb[i].flg, sb[i].sc);
        end
        sb.delete(i);
      end else if (sb[i].edge_no < edges) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL %s missed got edge=%0d expected edge=%0d",
                 sb[i].name, edges, sb[i].edge_no);
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got time=%0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    edges         = 0;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.pwm_in    = 1'b0;
    bus.dt_rise   = 16'd0;
    bus.dt_fall   = 16'd0;
    bus.brk       = 1'b0;
    bus.brk_clr   = 1'b0;

    // Reset
    step(1);
    expect_at(1, "reset", 0, 0, 0, 0, 8'd0);
    step(1);

    // T1: start-up through DT_FALL, 3 dead cycles
    rst_n       = 1'b1;
    bus.dt_rise = 16'd4;
    bus.dt_fall = 16'd3;
    bus.enable  = 1'b1;
    expect_at(1, "t1_dt1", 0, 0, 1, 0, 8'd0);
    expect_at(2, "t1_dt2", 0, 0, 1, 0, 8'd0);
    expect_at(3, "t1_dt3", 0, 0, 1, 0, 8'd0);
    expect_at(4, "t1_lo_on", 0, 1, 0, 0, 8'd0);
    expect_at(6, "t1_lo_hold", 0, 1, 0, 0, 8'd0);
    step(6);

    // T2: 20-cycle high pulse with dt_rise=4 then fall with dt_fall=3
    bus.pwm_in = 1'b1;
    expect_at(1, "t2_lo_off", 0, 0, 1, 0, 8'd0);
    expect_at(4, "t2_dt_last", 0, 0, 1, 0, 8'd0);
    expect_at(5, "t2_hi_on", 1, 0, 0, 0, 8'd0);
    expect_at(20, "t2_hi_hold", 1, 0, 0, 0, 8'd0);
    step(20);
    bus.pwm_in = 1'b0;
    expect_at(1, "t2_hi_off", 0, 0, 1, 0, 8'd0);
    expect_at(3, "t2_dtf_last", 0, 0, 1, 0, 8'd0);
    expect_at(4, "t2_lo_back", 0, 1, 0, 0, 8'd0);
    step(6);

    // T3: zero dead time behaves as one cycle
    bus.dt_rise = 16'd0;
    bus.dt_fall = 16'd0;
    for (int k = 0; k < 4; k++) begin
      bus.pwm_in = ~bus.pwm_in;
      expect_at(1, "t3_gap", 0, 0, 1, 0, 8'd0);
      expect_at(2, "t3_on", bus.pwm_in, ~bus.pwm_in, 0, 0, 8'd0);
      expect_at(6, "t3_hold", bus.pwm_in, ~bus.pwm_in, 0, 0, 8'd0);
      step(6);
    end

    // T4: 2-cycle pulse absorbed in DT_RISE with dt_rise=5
    bus.dt_rise = 16'd5;
    bus.pwm_in  = 1'b1;
    expect_at(1, "t4_dt1", 0, 0, 1, 0, 8'd0);
    expect_at(2, "t4_dt2", 0, 0, 1, 0, 8'd0);
    expect_at(3, "t4_absorb", 0, 1, 0, 0, 8'd1);
    step(2);
    bus.pwm_in = 1'b0;
    step(3);

    // T5: reach HI_ON, absorb one DT_FALL pulse, then break
    bus.dt_rise = 16'd2;
    bus.dt_fall = 16'd4;
    bus.pwm_in  = 1'b1;
    expect_at(3, "t5_hi_on", 1, 0, 0, 0, 8'd1);
    step(4);
    bus.pwm_in = 1'b0;
    expect_at(1, "t5_dtf", 0, 0, 1, 0, 8'd1);
    step(1);
    bus.pwm_in = 1'b1;
    expect_at(1, "t5_absorb_f", 1, 0, 0, 0, 8'd2);
    step(2);
    bus.brk = 1'b1;
    expect_at(1, "t5_brk", 0, 0, 0, 1, 8'd2);
    step(1);
    bus.brk    = 1'b0;
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    expect_at(1, "t5_latched_a", 0, 0, 0, 1, 8'd2);
    step(2);
    bus.enable = 1'b1;
    bus.pwm_in = 1'b1;
    expect_at(3, "t5_latched_b", 0, 0, 0, 1, 8'd2);
    step(3);
    bus.brk     = 1'b1;
    bus.brk_clr = 1'b1;
    expect_at(1, "t5_brk_wins", 0, 0, 0, 1, 8'd2);
    step(1);
    bus.brk = 1'b0;
    expect_at(1, "t5_clr", 0, 0, 0, 0, 8'd2);
    expect_at(2, "t5_restart", 0, 0, 1, 0, 8'd2);
    expect_at(4, "t5_hi_again", 1, 0, 0, 0, 8'd2);
    step(1);
    bus.brk_clr = 1'b0;
    step(4);

    // T6: reset mid-DT_RISE; a glitch between edges is ignored
    bus.dt_fall = 16'd3;
    bus.pwm_in  = 1'b0;
    expect_at(4, "t6_lo_on", 0, 1, 0, 0, 8'd2);
    step(5);
    bus.dt_rise = 16'd6;
    bus.pwm_in  = 1'b1;
    expect_at(1, "t6_dtr", 0, 0, 1, 0, 8'd2);
    step(1);
    expect_at(1, "t6_glitch", 0, 0, 1, 0, 8'd2);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1);
    rst_n = 1'b0;
    expect_at(1, "t6_reset", 0, 0, 0, 0, 8'd0);
    step(1);
    rst_n = 1'b1;
    expect_at(1, "t6_restart", 0, 0, 1, 0, 8'd0);
    step(1);

    // Saturation: 300 absorbed pulses leave short_cnt at 255
    bus.dt_rise = 16'd4;
    bus.dt_fall = 16'd4;
    bus.pwm_in  = 1'b0;
    expect_at(1, "sat_first", 0, 1, 0, 0, 8'd1);
    step(1);
    for (int i = 0; i < 299; i++) begin
      bus.pwm_in = 1'b1;
      step(1);
      bus.pwm_in = 1'b0;
      case (i)
        0:   expect_at(1, "sat_2", 0, 1, 0, 0, 8'd2);
        252: expect_at(1, "sat_254", 0, 1, 0, 0, 8'd254);
        253: expect_at(1, "sat_255", 0, 1, 0, 0, 8'd255);
        254: expect_at(1, "sat_hold", 0, 1, 0, 0, 8'd255);
        298: expect_at(1, "sat_final", 0, 1, 0, 0, 8'd255);
        default: ;
      endcase
      step(1);
    end
    step(2);

    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL leftover got pending=%0d expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
